pulse_freq_meter_32ch: RTL and testbench

//   32-channel rising-edge counter placed directly downstream of the 32-ch pulse debounce filter.

---
 rtl/pulse_freq_meter_32ch.sv | 149 ++++++++++++++
 tb/tb_pulse_freq_meter_32ch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_freq_meter_32ch.sv
// 32-channel rising-edge counter with a programmable gate window and a readable result bank.
// Optional FREQ_OVF_FLAG_EN: saturating counters plus a per-channel overflow flag output.
module pulse_freq_meter_32ch #(
    parameter int unsigned CH     = 32,
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned GATE_W = 26,
    localparam int unsigned AW    = $clog2(CH)
) (
    input  logic              clk_20m_i,
    input  logic              rst_i,
    input  logic [CH-1:0]     pulse_in_i,
    input  logic              meas_en_i,
    input  logic [GATE_W-1:0] gate_cfg_i,
    output logic              busy_o,
    output logic              meas_done_o,
    input  logic [AW-1:0]     rd_addr_i,
    input  logic              rd_en_i,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic              rd_valid_o
`ifdef FREQ_OVF_FLAG_EN
    ,
    output logic [CH-1:0]     ovf_flag_o
`endif
);

    typedef enum logic [1:0] {StIdle, StArm, StGate, StLatch} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e             state_q, state_d;
    logic [CH-1:0]      prev_q;
    logic [CH-1:0]      edge_det;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   cnt_q    [CH];
    logic [CNT_W-1:0]   cnt_d    [CH];
    logic [CNT_W-1:0]   result_q [CH];
    logic [CNT_W-1:0]   rd_data_q;
    logic               rd_valid_q;

    assign edge_det = pulse_in_i & ~prev_q;

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (meas_en_i) state_d = StArm;
            end
            StArm: begin
                // A zero gate length behaves as a single-cycle gate.
                gate_cnt_d = (gate_cfg_i == '0) ? '0 : gate_cfg_i - 1'b1;
                state_d    = StGate;
            end
            StGate: begin
                if (!meas_en_i) begin
                    state_d = StIdle;
                end else if (gate_cnt_q == '0) begin
                    state_d = StLatch;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                end
            end
            StLatch: begin
                state_d = meas_en_i ? StArm : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (state_q == StArm) begin
                cnt_d[i] = '0;
            end else if (state_q == StGate && edge_det[i]) begin
`ifdef FREQ_OVF_FLAG_EN
                if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + 1'b1;
`else
                cnt_d[i] = cnt_q[i] + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk_20m_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            prev_q     <= '0;
            gate_cnt_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i]    <= '0;
                result_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            prev_q     <= pulse_in_i;
            gate_cnt_q <= gate_cnt_d;
            rd_valid_q <= rd_en_i;
            // Non-blocking read of result_q gives the pre-latch value during LATCH.
            if (rd_en_i) rd_data_q <= result_q[rd_addr_i];
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (state_q == StLatch) result_q[i] <= cnt_q[i];
            end
        end
    end

`ifdef FREQ_OVF_FLAG_EN
    logic [CH-1:0] sat_vec;
    logic [CH-1:0] ovf_acc_q, ovf_acc_d;
    logic [CH-1:0] ovf_flag_q;

    // A channel overflows when an edge arrives while its counter is already pinned at max.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            sat_vec[i] = (cnt_q[i] == CntMax);
        end
    end

    always_comb begin
        ovf_acc_d = ovf_acc_q;
        if (state_q == StArm) begin
            ovf_acc_d = '0;
        end else if (state_q == StGate) begin
            ovf_acc_d = ovf_acc_q | (edge_det & sat_vec);
        end
    end

    always_ff @(posedge clk_20m_i) begin
        if (rst_i) begin
            ovf_acc_q  <= '0;
            ovf_flag_q <= '0;
        end else begin
            ovf_acc_q <= ovf_acc_d;
            if (state_q == StLatch) ovf_flag_q <= ovf_acc_q;
        end
    end

    assign ovf_flag_o = ovf_flag_q;
`endif

    assign busy_o      = (state_q != StIdle);
    assign meas_done_o = (state_q == StLatch);
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;

endmodule

// File: tb/tb_pulse_freq_meter_32ch.sv
// Scoreboard bench for pulse_freq_meter_32ch: a timeline reference model predicts latch
// instants, read data and busy; a negedge monitor pops and compares against the DUT.
module tb_pulse_freq_meter_32ch;

    localparam int unsigned CH     = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned GATE_W = 26;
    localparam int unsigned AW     = 5;
    localparam int unsigned MaxCnt = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     pulse_in;
    logic              meas_en;
    logic [GATE_W-1:0] gate_cfg;
    logic              busy;
    logic              meas_done;
    logic [AW-1:0]     rd_addr;
    logic              rd_en;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;
`ifdef FREQ_OVF_FLAG_EN
    logic [CH-1:0]     ovf_flag;
`endif

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;

    always #25 clk = ~clk;

    pulse_freq_meter_32ch #(
        .CH     (CH),
        .CNT_W  (CNT_W),
        .GATE_W (GATE_W)
    ) dut (
        .clk_20m_i   (clk),
        .rst_i       (rst),
        .pulse_in_i  (pulse_in),
        .meas_en_i   (meas_en),
        .gate_cfg_i  (gate_cfg),
        .busy_o      (busy),
        .meas_done_o (meas_done),
        .rd_addr_i   (rd_addr),
        .rd_en_i     (rd_en),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid)
`ifdef FREQ_OVF_FLAG_EN
        ,
        .ovf_flag_o  (ovf_flag)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: edge-indexed timeline of one measurement (ARM, gate edges, latch).
    int unsigned   cyc = 0;
    int unsigned   arm_e = 0;
    int unsigned   glen = 1;
    bit            run_m = 1'b0;
    int unsigned   cnt_m  [CH];
    int unsigned   bank_m [CH];
    logic [CH-1:0] prev_m = '0;
    logic [CH-1:0] ovf_acc_m = '0;
    logic [CH-1:0] ovf_m = '0;
    int unsigned   rd_q[$];
    int unsigned   done_q[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            run_m  = 1'b0;
            prev_m = '0;
            ovf_m  = '0;
            foreach (bank_m[i]) bank_m[i] = 0;
        end else begin
            if (rd_en) rd_q.push_back(bank_m[rd_addr]);
            if (run_m && cyc == arm_e) begin
                glen = (gate_cfg == '0) ? 1 : int'(gate_cfg);
                foreach (cnt_m[i]) cnt_m[i] = 0;
                ovf_acc_m = '0;
            end else if (run_m && cyc <= arm_e + glen) begin
                if (!meas_en) begin
                    run_m = 1'b0;
                end else begin
                    for (int i = 0; i < CH; i++) begin
                        if (pulse_in[i] && !prev_m[i]) begin
`ifdef FREQ_OVF_FLAG_EN
                            if (cnt_m[i] < MaxCnt) cnt_m[i]++;
                            else ovf_acc_m[i] = 1'b1;
`else
                            cnt_m[i] = (cnt_m[i] + 1) & MaxCnt;
`endif
                        end
                    end
                    if (cyc == arm_e + glen) done_q.push_back(cyc);
                end
            end else if (run_m) begin
                bank_m = cnt_m;
                ovf_m  = ovf_acc_m;
                if (meas_en) arm_e = cyc + 1;
                else run_m = 1'b0;
            end else if (meas_en) begin
                run_m = 1'b1;
                arm_e = cyc + 1;
            end
            prev_m = pulse_in;
        end
    end

    // Monitor: compares what the DUT presents after each active edge.
    always @(negedge clk) begin
        if (mon_on) begin
            check("busy", {63'd0, busy}, {63'd0, run_m});
            if (rd_q.size() > 0) begin
                int unsigned e;
                e = rd_q.pop_front();
                check("rd_valid", {63'd0, rd_valid}, 64'd1);
                check("rd_data", {56'd0, rd_data}, {32'd0, e});
            end else begin
                check("rd_valid_idle", {63'd0, rd_valid}, 64'd0);
            end
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                void'(done_q.pop_front());
                check("meas_done", {63'd0, meas_done}, 64'd1);
            end else begin
                check("meas_done_idle", {63'd0, meas_done}, 64'd0);
            end
`ifdef FREQ_OVF_FLAG_EN
            check("ovf_flag", {32'd0, ovf_flag}, {32'd0, ovf_m});
`endif
        end
    end

    function automatic logic [CH-1:0] pattern(input int mode, input int k, input int g);
        logic [CH-1:0] p;
        p = '0;
        case (mode)
            0: p[0] = (k >= 2) && ((k - 2) % 10 < 5);
            2: p[5] = (k == 1) || (k == g + 1);
            3: p[1] = 1'b1;
            4: p[1] = (k >= 2);
            5: p[2] = (k >= 2) && (k % 2 == 1);
            default: p = CH'($urandom & $urandom);
        endcase
        return p;
    endfunction

    // k counts the edge index from the first edge that samples meas_en=1.
    task automatic run_meas(input int gate, input int ngates, input int mode, input int stop_k,
                            input bit latch_rd, output logic [CNT_W-1:0] lat_data);
        int g;
        int total;
        g        = (gate == 0) ? 1 : gate;
        total    = ngates * (g + 2);
        gate_cfg = GATE_W'(gate);
        lat_data = '0;
        for (int k = 0; k <= total + 2; k++) begin
            @(negedge clk);
            if (k == g + 3) lat_data = rd_data;
            meas_en  = (k < total) && (k < stop_k);
            pulse_in = pattern(mode, k, g);
            rd_en    = latch_rd && (k == g + 2);
            rd_addr  = '0;
        end
        meas_en = 1'b0;
        rd_en   = 1'b0;
    endtask

    task automatic do_read(input int addr, output logic [CNT_W-1:0] d);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = addr[AW-1:0];
        @(negedge clk);
        rd_en = 1'b0;
        d     = rd_data;
    endtask

    initial begin
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] lat;
        rst      = 1'b1;
        meas_en  = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        pulse_in = '0;
        gate_cfg = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, meas_done}, 64'd0);
        check("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("reset_rd_data", {56'd0, rd_data}, 64'd0);
        rst    = 1'b0;
        mon_on = 1'b1;

        // Square wave on ch0, two back-to-back gates of 1000.
        run_meas(1000, 2, 0, 1 << 30, 1'b0, lat);
        do_read(0, d);
        check("t1_ch0", {56'd0, d}, 64'd100);
        do_read(7, d);
        check("t1_ch7", {56'd0, d}, 64'd0);

        // Abort at GATE cycle 400: bank keeps 100.
        run_meas(1000, 1, 0, 402, 1'b0, lat);
        check("t4_busy", {63'd0, busy}, 64'd0);
        do_read(0, d);
        check("t4_ch0", {56'd0, d}, 64'd100);

        // Read in the LATCH cycle returns the old value.
        run_meas(370, 1, 0, 1 << 30, 1'b1, lat);
        check("t5_latch_read", {56'd0, lat}, 64'd100);
        do_read(0, d);
        check("t5_ch0", {56'd0, d}, 64'd37);

        // ARM-cycle rise ignored, final-gate-cycle rise counted.
        run_meas(50, 1, 2, 1 << 30, 1'b0, lat);
        do_read(5, d);
        check("t2_ch5", {56'd0, d}, 64'd1);

        run_meas(0, 1, 4, 1 << 30, 1'b0, lat);
        do_read(1, d);
        check("gate0_rise_ch1", {56'd0, d}, 64'd1);
        run_meas(0, 1, 3, 1 << 30, 1'b0, lat);
        do_read(1, d);
        check("t3_ch1", {56'd0, d}, 64'd0);

        // 300 rises into an 8-bit counter.
        run_meas(600, 1, 5, 1 << 30, 1'b0, lat);
        do_read(2, d);
`ifdef FREQ_OVF_FLAG_EN
        check("wrap_ch2", {56'd0, d}, 64'd255);
        check("ovf_ch2", {63'd0, ovf_flag[2]}, 64'd1);
        check("ovf_ch0", {63'd0, ovf_flag[0]}, 64'd0);
`else
        check("wrap_ch2", {56'd0, d}, 64'd44);
`endif

        // Reset in the middle of a gate.
        gate_cfg = GATE_W'(100);
        meas_en  = 1'b1;
        repeat (50) begin
            @(negedge clk);
            pulse_in = CH'($urandom);
        end
        rst     = 1'b1;
        meas_en = 1'b0;
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        do_read(2, d);
        check("midrst_ch2", {56'd0, d}, 64'd0);

        // Random traffic: gates, aborts, gate_cfg changes and reads at any time.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            pulse_in = CH'($urandom & $urandom);
            if ($urandom_range(0, 149) == 0) meas_en = ~meas_en;
            if ($urandom_range(0, 39) == 0) gate_cfg = GATE_W'($urandom_range(0, 40));
            rd_en   = ($urandom_range(0, 2) == 0);
            rd_addr = AW'($urandom_range(0, CH - 1));
        end
        meas_en = 1'b0;
        rd_en   = 1'b0;
        repeat (50) @(negedge clk);
        for (int a = 0; a < CH; a++) do_read(a, d);
        repeat (2) @(negedge clk);
        check("done_pending", 64'(done_q.size()), 64'd0);
        check("read_pending", 64'(rd_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
